// File: rtl/d16_mem_unit.sv
`default_nettype none
// ============================================================================
// Module     : d16_mem_unit
// Description: d16 memory/writeback stage. Latches one ALU result, runs at
//              most one req/ack bus cycle (with timeout), then emits a single
//              cycle register/SP writeback or a fault completion.
//              Optional feature macro: BYTE_ACCESS_EN (byte loads/stores).
// Revision   : 1.0 - initial release
// ============================================================================
module d16_mem_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [1:0]  i_op,
  input  logic        i_byte_op,
  input  logic [15:0] i_alu_out,
  input  logic [15:0] i_alu_mem_data,
  input  logic        i_alu_write,
  input  logic [15:0] i_alu_sp,
  input  logic        i_sp_write,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic [1:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic        o_wb_en,
  output logic [15:0] o_wb_data,
  output logic        o_sp_wb_en,
  output logic [15:0] o_sp_wb_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_FLT  = 2'd3;

  localparam logic [1:0] C_OP_PASS  = 2'b00;
  localparam logic [1:0] C_OP_LOAD  = 2'b01;
  localparam logic [1:0] C_OP_STORE = 2'b10;

  // Last REQ cycle index that may still wait for ack.
  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

`ifdef BYTE_ACCESS_EN
  localparam logic C_BYTE_EN = 1'b1;
`else
  localparam logic C_BYTE_EN = 1'b0;
`endif

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [1:0]  r_op;
  logic        r_byte;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_alu_write;
  logic [15:0] r_sp;
  logic        r_sp_write;
  logic [15:0] r_rdata;
  logic [7:0]  r_timer;

  logic [1:0]  w_op_norm;
  logic        w_misalign;
  logic        w_byte;
  logic [15:0] w_load_data;

  // Reserved opcode behaves exactly like pass-through.
  assign w_op_norm  = (i_op == 2'b11) ? C_OP_PASS : i_op;
  // Odd address is only legal for a byte access when byte support is built in.
  assign w_misalign = i_alu_out[0] & ~(i_byte_op & C_BYTE_EN);
  assign w_byte     = r_byte & C_BYTE_EN;
  assign w_load_data = w_byte ? {8'h00, (r_addr[0] ? r_rdata[15:8] : r_rdata[7:0])}
                              : r_rdata;

  // State register; async reset drops mem_req immediately mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_en) begin
          if (w_op_norm == C_OP_PASS) w_state_nxt = S_WB;
          else if (w_misalign)        w_state_nxt = S_FLT;
          else                        w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (i_mem_ack)                  w_state_nxt = S_WB;
        else if (r_timer == C_TMO_LAST) w_state_nxt = S_FLT;
      end
      S_WB:    w_state_nxt = S_IDLE;
      S_FLT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the ALU result only when a new operation is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= C_OP_PASS;
      r_byte      <= 1'b0;
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_alu_write <= 1'b0;
      r_sp        <= 16'h0000;
      r_sp_write  <= 1'b0;
    end else if (r_state == S_IDLE && i_en) begin
      r_op        <= w_op_norm;
      r_byte      <= i_byte_op;
      r_addr      <= i_alu_out;
      r_wdata     <= i_alu_mem_data;
      r_alu_write <= i_alu_write;
      r_sp        <= i_alu_sp;
      r_sp_write  <= i_sp_write;
    end
  end

  // Load data capture on the accepting ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             r_rdata <= 16'h0000;
    else if (r_state == S_REQ && i_mem_ack && r_op == C_OP_LOAD) r_rdata <= i_mem_rdata;
  end

  // Wait timer: counts REQ cycles without ack, cleared outside REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_timer <= 8'd0;
    else if (r_state != S_REQ) r_timer <= 8'd0;
    else if (!i_mem_ack)       r_timer <= r_timer + 8'd1;
  end

  // Moore outputs: everything is zero outside the state that owns it.
  always_comb begin
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = 16'h0000;
    o_mem_wdata  = 16'h0000;
    o_mem_be     = 2'b00;
    o_wb_en      = 1'b0;
    o_wb_data    = 16'h0000;
    o_sp_wb_en   = 1'b0;
    o_sp_wb_data = 16'h0000;
    o_done       = 1'b0;
    o_fault      = 1'b0;
    o_busy       = (r_state != S_IDLE);
    case (r_state)
      S_REQ: begin
        o_mem_req   = 1'b1;
        o_mem_we    = (r_op == C_OP_STORE);
        o_mem_addr  = {r_addr[15:1], 1'b0};
        o_mem_wdata = w_byte ? {2{r_wdata[7:0]}} : r_wdata;
        o_mem_be    = w_byte ? (r_addr[0] ? 2'b10 : 2'b01) : 2'b11;
      end
      S_WB: begin
        o_done       = 1'b1;
        o_wb_en      = r_alu_write & (r_op != C_OP_STORE);
        o_wb_data    = (r_op == C_OP_LOAD) ? w_load_data : r_addr;
        o_sp_wb_en   = r_sp_write;
        o_sp_wb_data = r_sp;
      end
      S_FLT: begin
        o_done  = 1'b1;
        o_fault = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
